// File: rtl/micro_controller_param.sv
// ----------------------------------------------------------------------------
// micro_controller_param
//   Multi-cycle accumulator microcontroller. The program is streamed in over a
//   valid/ready load port. The core then runs FETCH -> DECODE -> EXECUTE,
//   which takes 3 cycles per instruction, until it executes HALT. From HALT,
//   restart re-runs the program from pc=0.
//
//   Instruction word (INSTR_W = 8 + DATA_W): [op 4][mode 4][operand DATA_W]
//
//   Optional feature macro: MC_IRQ_EN
//     Adds a level interrupt: EPC, an IE bit, saved flags, and the RETI opcode.
//     When MC_IRQ_EN is undefined, irq is ignored and opcode 8 is illegal.
//
// Ports
//   clk, rst_n             clock, async active-low reset
//   load_valid/data/last   program load stream (accepted only in LOAD)
//   load_ready             high only in LOAD
//   restart                leave HALT and re-run from pc=0
//   irq                    level interrupt request (MC_IRQ_EN only)
//   pc, acc, sr            program counter, accumulator, flags {Z,C,S,O}
//   halted                 high in HALT
//   retire                 pulses for the one cycle of each EXECUTE
//   illegal                pulses in EXECUTE on an undefined opcode
// ----------------------------------------------------------------------------
module micro_controller_param #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PC_W       = 8,
    parameter int unsigned DMEM_AW    = 4,
    parameter int unsigned IRQ_VECTOR = 32'h0000_00F0,
    localparam int unsigned INSTR_W   = 8 + DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_valid,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               load_last,
    output logic               load_ready,
    input  logic               restart,
    input  logic               irq,
    output logic [PC_W-1:0]    pc,
    output logic [DATA_W-1:0]  acc,
    output logic [3:0]         sr,
    output logic               halted,
    output logic               retire,
    output logic               illegal
);

    localparam int unsigned Msb = DATA_W - 1;

    localparam logic [3:0] OpNop    = 4'h0;
    localparam logic [3:0] OpHalt   = 4'h1;
    localparam logic [3:0] OpJmp    = 4'h2;
    localparam logic [3:0] OpJz     = 4'h3;
    localparam logic [3:0] OpJc     = 4'h4;
    localparam logic [3:0] OpAluImm = 4'h5;
    localparam logic [3:0] OpAluMem = 4'h6;
    localparam logic [3:0] OpAluSt  = 4'h7;
`ifdef MC_IRQ_EN
    localparam logic [3:0] OpReti   = 4'h8;
`endif

    localparam logic [3:0] AluAdd  = 4'h0;
    localparam logic [3:0] AluSub  = 4'h1;
    localparam logic [3:0] AluAnd  = 4'h2;
    localparam logic [3:0] AluOr   = 4'h3;
    localparam logic [3:0] AluXor  = 4'h4;
    localparam logic [3:0] AluNot  = 4'h5;
    localparam logic [3:0] AluShl  = 4'h6;
    localparam logic [3:0] AluShr  = 4'h7;
    localparam logic [3:0] AluPass = 4'h8;
    localparam logic [3:0] AluInc  = 4'h9;
    localparam logic [3:0] AluDec  = 4'hA;

    typedef enum logic [2:0] {
        StLoad,
        StFetch,
        StDecode,
        StExecute,
        StHalt
    } state_e;

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [PC_W-1:0]     load_ptr_q, load_ptr_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   dr_q, dr_d;
    logic [3:0]          sr_q, sr_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;

`ifdef MC_IRQ_EN
    logic                ie_q, ie_d;
    logic [PC_W-1:0]     epc_q, epc_d;
    logic [3:0]          sflags_q, sflags_d;
`else
    logic                unused_irq;
    logic [PC_W-1:0]     unused_irq_vector;
    assign unused_irq        = irq;
    assign unused_irq_vector = PC_W'(IRQ_VECTOR);
`endif

    // Memories are not reset; their contents come only from the load port and stores.
    logic [INSTR_W-1:0]  pmem_q [2**PC_W];
    logic [DATA_W-1:0]   dmem_q [2**DMEM_AW];
    logic                pmem_we;
    logic                dmem_we;

    // Instruction fields
    logic [3:0]          op;
    logic [3:0]          mode;
    logic [DATA_W-1:0]   operand;
    logic [DMEM_AW-1:0]  dm_addr;
    logic [PC_W-1:0]     jmp_target;
    logic [PC_W-1:0]     pc_inc;

    assign op         = ir_q[INSTR_W-1 -: 4];
    assign mode       = ir_q[DATA_W +: 4];
    assign operand    = ir_q[DATA_W-1:0];
    assign dm_addr    = operand[DMEM_AW-1:0];
    assign jmp_target = PC_W'(operand);
    assign pc_inc     = pc_q + PC_W'(1);

    // ALU
    logic [DATA_W-1:0]   op2;
    logic [DATA_W-1:0]   alu_res;
    logic [DATA_W:0]     alu_sum;
    logic                alu_c;
    logic                alu_o;
    logic [3:0]          alu_flags;

    assign op2 = (op == OpAluImm) ? operand : dr_q;

    always_comb begin
        alu_res = acc_q;
        alu_sum = '0;
        alu_c   = sr_q[2];
        alu_o   = sr_q[0];
        case (mode)
            AluAdd: begin
                alu_sum = {1'b0, acc_q} + {1'b0, op2};
                alu_res = alu_sum[Msb:0];
                alu_c   = alu_sum[DATA_W];
                alu_o   = (acc_q[Msb] == op2[Msb]) && (alu_res[Msb] != acc_q[Msb]);
            end
            AluSub: begin
                // Top bit of the widened difference is the borrow.
                alu_sum = {1'b0, acc_q} - {1'b0, op2};
                alu_res = alu_sum[Msb:0];
                alu_c   = alu_sum[DATA_W];
                alu_o   = (acc_q[Msb] != op2[Msb]) && (alu_res[Msb] != acc_q[Msb]);
            end
            AluAnd:  alu_res = acc_q & op2;
            AluOr:   alu_res = acc_q | op2;
            AluXor:  alu_res = acc_q ^ op2;
            AluNot:  alu_res = ~acc_q;
            AluShl: begin
                alu_res = {acc_q[Msb-1:0], 1'b0};
                alu_c   = acc_q[Msb];
                alu_o   = 1'b0;
            end
            AluShr: begin
                alu_res = {1'b0, acc_q[Msb:1]};
                alu_c   = acc_q[0];
                alu_o   = 1'b0;
            end
            AluPass: alu_res = op2;
            AluInc: begin
                alu_sum = {1'b0, acc_q} + (DATA_W+1)'(1);
                alu_res = alu_sum[Msb:0];
                alu_c   = alu_sum[DATA_W];
                alu_o   = alu_res[Msb] & ~acc_q[Msb];
            end
            AluDec: begin
                alu_sum = {1'b0, acc_q} - (DATA_W+1)'(1);
                alu_res = alu_sum[Msb:0];
                alu_c   = alu_sum[DATA_W];
                alu_o   = acc_q[Msb] & ~alu_res[Msb];
            end
            default: alu_res = acc_q;
        endcase
    end

    assign alu_flags = {alu_res == '0, alu_c, alu_res[Msb], alu_o};

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        load_ptr_d = load_ptr_q;
        acc_d      = acc_q;
        dr_d       = dr_q;
        sr_d       = sr_q;
        ir_d       = ir_q;
        pmem_we    = 1'b0;
        dmem_we    = 1'b0;
        illegal    = 1'b0;
`ifdef MC_IRQ_EN
        ie_d       = ie_q;
        epc_d      = epc_q;
        sflags_d   = sflags_q;
`endif
        unique case (state_q)
            StLoad: begin
                if (load_valid) begin
                    pmem_we    = 1'b1;
                    load_ptr_d = load_ptr_q + PC_W'(1);
                    // A full memory ends the load even without load_last.
                    if (load_last || (&load_ptr_q)) begin
                        state_d = StFetch;
                        pc_d    = '0;
                        acc_d   = '0;
                        sr_d    = '0;
`ifdef MC_IRQ_EN
                        ie_d    = 1'b1;
`endif
                    end
                end
            end
            StFetch: begin
                ir_d    = pmem_q[pc_q];
                state_d = StDecode;
            end
            StDecode: begin
                dr_d    = dmem_q[dm_addr];
                state_d = StExecute;
            end
            StExecute: begin
                state_d = StFetch;
                pc_d    = pc_inc;
                case (op)
                    OpNop: ;
                    OpHalt: state_d = StHalt;
                    OpJmp:  pc_d = jmp_target;
                    OpJz:   if (sr_q[3]) pc_d = jmp_target;
                    OpJc:   if (sr_q[2]) pc_d = jmp_target;
                    OpAluImm, OpAluMem: begin
                        acc_d = alu_res;
                        sr_d  = alu_flags;
                    end
                    OpAluSt: begin
                        dmem_we = 1'b1;
                        sr_d    = alu_flags;
                    end
`ifdef MC_IRQ_EN
                    OpReti: begin
                        pc_d = epc_q;
                        sr_d = sflags_q;
                        ie_d = 1'b1;
                    end
`endif
                    default: illegal = 1'b1;
                endcase
`ifdef MC_IRQ_EN
                // Interrupt entry replaces the pc update of this EXECUTE, so it costs no cycles.
                if (irq && ie_q && !(op inside {OpJmp, OpJz, OpJc, OpHalt})) begin
                    epc_d    = pc_d;
                    sflags_d = sr_d;
                    ie_d     = 1'b0;
                    pc_d     = PC_W'(IRQ_VECTOR);
                end
`endif
            end
            StHalt: begin
                if (restart) begin
                    state_d = StFetch;
                    pc_d    = '0;
                    acc_d   = '0;
                    sr_d    = '0;
`ifdef MC_IRQ_EN
                    ie_d    = 1'b1;
`endif
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StLoad;
            pc_q       <= '0;
            load_ptr_q <= '0;
            acc_q      <= '0;
            dr_q       <= '0;
            sr_q       <= '0;
            ir_q       <= '0;
`ifdef MC_IRQ_EN
            ie_q       <= 1'b0;
            epc_q      <= '0;
            sflags_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            load_ptr_q <= load_ptr_d;
            acc_q      <= acc_d;
            dr_q       <= dr_d;
            sr_q       <= sr_d;
            ir_q       <= ir_d;
`ifdef MC_IRQ_EN
            ie_q       <= ie_d;
            epc_q      <= epc_d;
            sflags_q   <= sflags_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (pmem_we) pmem_q[load_ptr_q] <= load_data;
        if (dmem_we) dmem_q[dm_addr] <= alu_res;
    end

    assign load_ready = (state_q == StLoad);
    assign halted     = (state_q == StHalt);
    assign retire     = (state_q == StExecute);
    assign pc         = pc_q;
    assign acc        = acc_q;
    assign sr         = sr_q;

endmodule

// File: tb/tb_micro_controller_param.sv
// Bench for micro_controller_param in its default build (8-bit data, 8-bit pc).
// Each program's expected per-retire results {pc, acc, sr, illegal} are queued
// when the program is loaded. They are popped and compared as each instruction
// retires.
module tb_micro_controller_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = '0;
    logic        load_last = 1'b0;
    logic        load_ready;
    logic        restart = 1'b0;
    logic        irq = 1'b0;
    logic [7:0]  pc;
    logic [7:0]  acc;
    logic [3:0]  sr;
    logic        halted;
    logic        retire;
    logic        illegal;

    micro_controller_param dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .restart    (restart),
        .irq        (irq),
        .pc         (pc),
        .acc        (acc),
        .sr         (sr),
        .halted     (halted),
        .retire     (retire),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] acc;
        logic [3:0] sr;
        logic       ill;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] prog[$];
    int          total = 0;
    int          bad = 0;

    task automatic do_reset();
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        restart    = 1'b0;
        sb.delete();
        prog.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Streams prog[] one beat per cycle and returns #1 after the final beat's edge.
    task automatic load_prog(input bit use_last);
        for (int i = 0; i < prog.size(); i++) begin
            @(negedge clk);
            load_valid = 1'b1;
            load_data  = prog[i];
            load_last  = use_last && (i == prog.size() - 1);
        end
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    // Waits, within a bounded number of cycles, for a retire pulse. Returns #1
    // after the EXECUTE edge, when the results are visible.
    task automatic wait_retire(output int cyc, output logic ill, output bit tmo);
        cyc = 0;
        ill = 1'b0;
        tmo = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (retire) begin
                ill = illegal;
                @(posedge clk);
                #1;
                cyc++;
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total += 7;
        if (pc !== 8'h00)      begin bad++; $display("FAIL reset pc: got %h want 00", pc); end
        if (acc !== 8'h00)     begin bad++; $display("FAIL reset acc: got %h want 00", acc); end
        if (sr !== 4'h0)       begin bad++; $display("FAIL reset sr: got %b want 0000", sr); end
        if (halted !== 1'b0)   begin bad++; $display("FAIL reset halted: got %b want 0", halted); end
        if (retire !== 1'b0)   begin bad++; $display("FAIL reset retire: got %b want 0", retire); end
        if (illegal !== 1'b0)  begin bad++; $display("FAIL reset illegal: got %b want 0", illegal); end
        if (load_ready !== 1'b1) begin bad++; $display("FAIL reset load_ready: got %b want 1", load_ready); end
    endtask

    task automatic test_basic();
        int   cyc;
        int   sum;
        logic il;
        bit   tmo;
        exp_t e;
        do_reset();
        prog = '{16'h5003, 16'h5004, 16'h1000};
        sb.push_back({8'h01, 8'h03, 4'h0, 1'b0});
        sb.push_back({8'h02, 8'h07, 4'h0, 1'b0});
        sb.push_back({8'h03, 8'h07, 4'h0, 1'b0});
        load_prog(1'b1);
        total++;
        if (load_ready !== 1'b0) begin bad++; $display("FAIL basic load_ready: got %b want 0", load_ready); end
        sum = 0;
        while (sb.size() > 0) begin
            wait_retire(cyc, il, tmo);
            sum += cyc;
            e = sb.pop_front();
            total++;
            if (tmo) begin
                bad++; $display("FAIL basic timeout: no retire, want pc=%h", e.pc);
            end else if ({pc, acc, sr, il} !== e) begin
                bad++;
                $display("FAIL basic step: got pc=%h acc=%h sr=%b ill=%b want pc=%h acc=%h sr=%b ill=%b",
                         pc, acc, sr, il, e.pc, e.acc, e.sr, e.ill);
            end
        end
        total += 2;
        if (sum !== 9)       begin bad++; $display("FAIL basic cycles: got %0d want 9", sum); end
        if (halted !== 1'b1) begin bad++; $display("FAIL basic halted: got %b want 1", halted); end
    endtask

    task automatic test_alu();
        int   cyc;
        logic il;
        bit   tmo;
        exp_t e;
        do_reset();
        prog = '{16'h5801, 16'h50FF, 16'h5101, 16'h5900, 16'h5A00, 16'h5600, 16'h5700,
                 16'h5900, 16'h520F, 16'h53A5, 16'h54FF, 16'h5500, 16'h5B33, 16'h1000};
        sb.push_back({8'h01, 8'h01, 4'b0000, 1'b0}); // PASS 01
        sb.push_back({8'h02, 8'h00, 4'b1100, 1'b0}); // ADD FF: carry, zero
        sb.push_back({8'h03, 8'hFF, 4'b0110, 1'b0}); // SUB 01: borrow, sign
        sb.push_back({8'h04, 8'h00, 4'b1100, 1'b0}); // INC FF
        sb.push_back({8'h05, 8'hFF, 4'b0110, 1'b0}); // DEC 00
        sb.push_back({8'h06, 8'hFE, 4'b0110, 1'b0}); // SHL
        sb.push_back({8'h07, 8'h7F, 4'b0000, 1'b0}); // SHR
        sb.push_back({8'h08, 8'h80, 4'b0011, 1'b0}); // INC 7F: overflow
        sb.push_back({8'h09, 8'h00, 4'b1001, 1'b0}); // AND: C,O held
        sb.push_back({8'h0A, 8'hA5, 4'b0011, 1'b0}); // OR
        sb.push_back({8'h0B, 8'h5A, 4'b0001, 1'b0}); // XOR
        sb.push_back({8'h0C, 8'hA5, 4'b0011, 1'b0}); // NOT
        sb.push_back({8'h0D, 8'hA5, 4'b0011, 1'b0}); // mode B: pass acc
        sb.push_back({8'h0E, 8'hA5, 4'b0011, 1'b0}); // HALT
        load_prog(1'b1);
        while (sb.size() > 0) begin
            wait_retire(cyc, il, tmo);
            e = sb.pop_front();
            total++;
            if (tmo) begin
                bad++; $display("FAIL alu timeout: no retire, want pc=%h", e.pc);
            end else if ({pc, acc, sr, il} !== e) begin
                bad++;
                $display("FAIL alu step: got pc=%h acc=%h sr=%b ill=%b want pc=%h acc=%h sr=%b ill=%b",
                         pc, acc, sr, il, e.pc, e.acc, e.sr, e.ill);
            end
        end
    endtask

    task automatic test_dmem();
        int   cyc;
        logic il;
        bit   tmo;
        exp_t e;
        do_reset();
        prog = '{16'h5805, 16'h7B02, 16'h5803, 16'h7002, 16'h6802, 16'h5800, 16'h6812, 16'h1000};
        sb.push_back({8'h01, 8'h05, 4'b0000, 1'b0});
        sb.push_back({8'h02, 8'h05, 4'b0000, 1'b0}); // DMem[2] = 05
        sb.push_back({8'h03, 8'h03, 4'b0000, 1'b0});
        sb.push_back({8'h04, 8'h03, 4'b0000, 1'b0}); // DMem[2] = 03 + 05, acc unchanged
        sb.push_back({8'h05, 8'h08, 4'b0000, 1'b0}); // reads the value just stored
        sb.push_back({8'h06, 8'h00, 4'b1000, 1'b0});
        sb.push_back({8'h07, 8'h08, 4'b0000, 1'b0}); // address 12 aliases to 2
        sb.push_back({8'h08, 8'h08, 4'b0000, 1'b0});
        load_prog(1'b1);
        while (sb.size() > 0) begin
            wait_retire(cyc, il, tmo);
            e = sb.pop_front();
            total++;
            if (tmo) begin
                bad++; $display("FAIL dmem timeout: no retire, want pc=%h", e.pc);
            end else if ({pc, acc, sr, il} !== e) begin
                bad++;
                $display("FAIL dmem step: got pc=%h acc=%h sr=%b ill=%b want pc=%h acc=%h sr=%b ill=%b",
                         pc, acc, sr, il, e.pc, e.acc, e.sr, e.ill);
            end
        end
    endtask

    // Fills all 256 words with no load_last; the load must end on the final beat.
    task automatic test_jumps();
        int   cyc;
        logic il;
        bit   tmo;
        exp_t e;
        do_reset();
        for (int i = 0; i < 256; i++) prog.push_back(16'h0000);
        prog[8'h00] = 16'h4020; // JC 20
        prog[8'h01] = 16'h5801;
        prog[8'h02] = 16'h3010; // JZ 10, not taken
        prog[8'h03] = 16'h5800;
        prog[8'h04] = 16'h3010; // JZ 10, taken
        prog[8'h10] = 16'h5101; // 00 - 01 sets C
        prog[8'h11] = 16'h20FE; // JMP FE
        prog[8'hFE] = 16'hF000; // illegal
        prog[8'hFF] = 16'h9000; // illegal, pc wraps to 00
        prog[8'h20] = 16'h1000;
        sb.push_back({8'h01, 8'h00, 4'h0, 1'b0});
        sb.push_back({8'h02, 8'h01, 4'h0, 1'b0});
        sb.push_back({8'h03, 8'h01, 4'h0, 1'b0});
        sb.push_back({8'h04, 8'h00, 4'h8, 1'b0});
        sb.push_back({8'h10, 8'h00, 4'h8, 1'b0});
        sb.push_back({8'h11, 8'hFF, 4'h6, 1'b0});
        sb.push_back({8'hFE, 8'hFF, 4'h6, 1'b0});
        sb.push_back({8'hFF, 8'hFF, 4'h6, 1'b1});
        sb.push_back({8'h00, 8'hFF, 4'h6, 1'b1});
        sb.push_back({8'h20, 8'hFF, 4'h6, 1'b0});
        sb.push_back({8'h21, 8'hFF, 4'h6, 1'b0});
        load_prog(1'b0);
        total++;
        if (load_ready !== 1'b0) begin bad++; $display("FAIL full_load load_ready: got %b want 0", load_ready); end
        while (sb.size() > 0) begin
            wait_retire(cyc, il, tmo);
            e = sb.pop_front();
            total++;
            if (tmo) begin
                bad++; $display("FAIL jump timeout: no retire, want pc=%h", e.pc);
            end else if ({pc, acc, sr, il} !== e) begin
                bad++;
                $display("FAIL jump step: got pc=%h acc=%h sr=%b ill=%b want pc=%h acc=%h sr=%b ill=%b",
                         pc, acc, sr, il, e.pc, e.acc, e.sr, e.ill);
            end
        end
        total++;
        if (halted !== 1'b1) begin bad++; $display("FAIL jump halted: got %b want 1", halted); end
    endtask

    // Continues from the halted jump program.
    task automatic test_restart();
        int   cyc;
        logic il;
        bit   tmo;
        exp_t e;
        @(negedge clk);
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        total += 4;
        if (halted !== 1'b0) begin bad++; $display("FAIL restart halted: got %b want 0", halted); end
        if (pc !== 8'h00)    begin bad++; $display("FAIL restart pc: got %h want 00", pc); end
        if (acc !== 8'h00)   begin bad++; $display("FAIL restart acc: got %h want 00", acc); end
        if (sr !== 4'h0)     begin bad++; $display("FAIL restart sr: got %b want 0000", sr); end
        sb.push_back({8'h01, 8'h00, 4'h0, 1'b0}); // JC not taken: C cleared
        sb.push_back({8'h02, 8'h01, 4'h0, 1'b0});
        sb.push_back({8'h03, 8'h01, 4'h0, 1'b0}); // after an ignored restart
        for (int n = 0; n < 3; n++) begin
            if (n == 2) begin
                restart = 1'b1;
                @(posedge clk);
                #1;
                restart = 1'b0;
            end
            wait_retire(cyc, il, tmo);
            e = sb.pop_front();
            total++;
            if (tmo) begin
                bad++; $display("FAIL restart timeout: no retire, want pc=%h", e.pc);
            end else if ({pc, acc, sr, il} !== e) begin
                bad++;
                $display("FAIL restart step: got pc=%h acc=%h sr=%b ill=%b want pc=%h acc=%h sr=%b ill=%b",
                         pc, acc, sr, il, e.pc, e.acc, e.sr, e.ill);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (retire) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen) begin bad++; $display("FAIL midreset timeout: retire got 0 want 1"); end
        rst_n = 1'b0;
        #1;
        total += 4;
        if (load_ready !== 1'b1) begin bad++; $display("FAIL midreset load_ready: got %b want 1", load_ready); end
        if (acc !== 8'h00)       begin bad++; $display("FAIL midreset acc: got %h want 00", acc); end
        if (pc !== 8'h00)        begin bad++; $display("FAIL midreset pc: got %h want 00", pc); end
        if (retire !== 1'b0)     begin bad++; $display("FAIL midreset retire: got %b want 0", retire); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_alu();
        test_dmem();
        test_jumps();
        test_restart();
        test_reset_mid();
        test_basic(); // reload after a mid-run reset starts from word 0
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
